// File: rtl/sram_ctrl_pkg.sv
// Types shared by the memory-port endpoints: request/transaction structs and
// the response-kind tag carried down the SRAM latency pipe.
package sram_ctrl_pkg;

  localparam int MADDR_W = 32;
  localparam int MDATA_W = 32;

  typedef enum logic [1:0] {RK_READ, RK_WRITE, RK_ERR} resp_kind_e;

  typedef struct packed {
    logic [MADDR_W-1:0]   addr;
    logic                 we;
    logic [MDATA_W-1:0]   data;
    logic [MDATA_W/8-1:0] be;
  } mreq_t;

  typedef struct packed {
    logic       vld;
    resp_kind_e kind;
  } mtrans_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage, combinational head. Pointers run
// modulo 2*DEPTH so full and empty are distinguishable for any DEPTH.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(2*DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IW-1:0] idx(input logic [PW-1:0] p);
    return (p >= PW'(DEPTH)) ? IW'(p - PW'(DEPTH)) : IW'(p);
  endfunction

  always_comb begin
    if (wptr >= rptr) count = wptr - rptr;
    else              count = wptr + PW'(2*DEPTH) - rptr;
  end

  assign empty    = (wptr == rptr);
  assign full     = (count == PW'(DEPTH));
  // a pop in the same cycle frees the slot, so a push into a full FIFO is legal then
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[idx(rptr)];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop)  rptr <= inc(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[idx(wptr)] <= push_data;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Flat memory-port endpoint onto a single-port synchronous SRAM. Credits cover
// the latency pipe plus the response FIFO, so responses can be backpressured.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  SRAM_AW    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h80000000,
  parameter int                  RD_LATENCY = 1,
  parameter int                  RESP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_we,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [DATA_WIDTH/8-1:0] mem_req_be,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  output logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    mem_resp_valid,
  input  logic                    mem_resp_ready,
  output logic                    sram_ce,
  output logic                    sram_we,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [DATA_WIDTH/8-1:0] sram_be,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    bus_err
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int FW  = $clog2(RESP_DEPTH) + 1;
  localparam int CW  = $clog2(RESP_DEPTH + RD_LATENCY + 1) + 1;
  localparam logic [AW1-1:0] SPAN = AW1'(1) << (SRAM_AW + 2);

  logic                  acc, in_range;
  logic [ADDR_WIDTH-1:0] off;
  resp_kind_e            kind0;
  logic [RD_LATENCY:1]   vld_pipe;
  resp_kind_e            kind_pipe [1:RD_LATENCY];
  logic [CW-1:0]         inflight, outstanding;
  logic [DATA_WIDTH-1:0] push_word, fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_count;

  // request side: SRAM is driven combinationally in the accept cycle
  assign off      = mem_req_addr - BASE_ADDR;
  assign in_range = (mem_req_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign acc      = mem_req_valid && mem_req_ready;

  assign sram_ce    = acc && in_range;
  assign sram_we    = acc && mem_req_we;
  assign sram_addr  = off[SRAM_AW+1:2];
  assign sram_be    = mem_req_we ? mem_req_be : '1;
  assign sram_wdata = mem_req_data;
  assign bus_err    = acc && !in_range;

  always_comb begin
    kind0 = RK_READ;
    if (!in_range)       kind0 = RK_ERR;
    else if (mem_req_we) kind0 = RK_WRITE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    kind_pipe[1] <= kind0;
    for (int i = 2; i <= RD_LATENCY; i++) kind_pipe[i] <= kind_pipe[i-1];
  end

  always_comb begin
    case (kind_pipe[RD_LATENCY])
      RK_READ:  push_word = sram_rdata;
      RK_WRITE: push_word = '0;
      default:  push_word = '1;
    endcase
  end

  // credits: everything accepted but not yet popped by the core
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  assign outstanding   = inflight + CW'(fifo_count);
  assign mem_req_ready = !rst && !fifo_full && (outstanding < CW'(RESP_DEPTH));

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[RD_LATENCY]),
    .push_data (push_word),
    .pop       (mem_resp_valid && mem_resp_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_resp_valid = !fifo_empty;
  assign mem_resp_data  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: SRAM model plus a flat-array reference of
// the memory map; every accepted request predicts its response word.
module tb_sram_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] mem_req_addr = 0;
  logic        mem_req_we = 0;
  logic [31:0] mem_req_data = 0;
  logic [3:0]  mem_req_be = 0;
  logic        mem_req_valid = 0;
  logic        mem_req_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_valid;
  logic        mem_resp_ready = 1;
  logic        sram_ce, sram_we;
  logic [15:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 0;
  logic        bus_err;

  sram_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_data(mem_req_data),
    .mem_req_be(mem_req_be), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // single-port SRAM, read latency 1
  bit [31:0] sram_mem [65536];
  always @(posedge clk) begin : sram_model
    logic [31:0] w;
    if (sram_ce) begin
      if (sram_we) begin
        w = sram_mem[sram_addr];
        for (int i = 0; i < 4; i++) if (sram_be[i]) w[8*i +: 8] = sram_wdata[8*i +: 8];
        sram_mem[sram_addr] <= w;
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  bit [31:0]   ref_mem [65536];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int n_vec = 0, n_err = 0, err_cnt = 0;
  logic last_ce, last_we, last_err;
  logic [15:0] last_addr;

  function automatic logic [31:0] ref_access(input logic [31:0] a, input logic we,
                                             input logic [31:0] d, input logic [3:0] be);
    longint unsigned ua = 64'(a);
    int w;
    if (ua < 64'h8000_0000 || ua >= 64'h8000_0000 + 4*65536) return 32'hFFFF_FFFF;
    w = int'((ua - 64'h8000_0000) / 4);
    if (!we) return ref_mem[w];
    for (int i = 0; i < 4; i++) if (be[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_resp_valid && mem_resp_ready) got_q.push_back(mem_resp_data);
      if (bus_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] be);
    bit ok = 0;
    mem_req_addr = a; mem_req_we = we; mem_req_data = d; mem_req_be = be; mem_req_valid = 1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        ok = 1;
        last_ce = sram_ce; last_we = sram_we; last_addr = sram_addr; last_err = bus_err;
      end
      step();
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout addr %h never accepted", a);
    end else exp_q.push_back(ref_access(a, we, d, be));
  endtask

  task automatic wait_resps(input int n);
    for (int t = 0; t < 300 && got_q.size() < n; t++) @(negedge clk);
    if (got_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL wait_resps got %0d responses, need %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1; mem_req_valid = 0; mem_resp_ready = 1;
    step(); step(); step();
    @(negedge clk);
    n_vec++;
    if ({mem_req_ready, mem_resp_valid, sram_ce, sram_we, bus_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b exp 00000",
                        {mem_req_ready, mem_resp_valid, sram_ce, sram_we, bus_err});
    end
    n_vec++;
    if (mem_resp_data !== 32'h0) begin
      n_err++; $display("FAIL reset_data got %h exp 0", mem_resp_data);
    end
    step(); rst = 0;
    @(negedge clk);
    n_vec++;
    if (mem_req_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset got %b exp 1", mem_req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sram_ce !== 1'b0 || mem_resp_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL idle_quiet got %0d active cycles exp 0", bad);
    end
    step();
  endtask

  task automatic test_write_read();
    send(32'h8000_0010, 1, 32'hCAFE_F00D, 4'hF);
    mem_req_valid = 0;
    n_vec++;
    if ({last_ce, last_we, last_addr} !== {1'b1, 1'b1, 16'd4}) begin
      n_err++; $display("FAIL write_sram got ce=%b we=%b addr=%0d exp ce=1 we=1 addr=4",
                        last_ce, last_we, last_addr);
    end
    @(negedge clk);
    n_vec++;
    if (mem_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_early got valid %b exp 0", mem_resp_valid);
    end
    step();
    @(negedge clk);
    n_vec++;
    if (mem_resp_valid !== 1'b1) begin
      n_err++; $display("FAIL latency_on_time got valid %b exp 1", mem_resp_valid);
    end
    step();
    send(32'h8000_0010, 0, 32'h0, 4'hF);
    mem_req_valid = 0;
    wait_resps(2); step();
    n_vec++;
    if (got_q[0] !== 32'h0 || got_q[1] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL write_read got %h,%h exp 00000000,cafef00d", got_q[0], got_q[1]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_byte_en();
    send(32'h8000_0100, 1, 32'h1122_3344, 4'hF);
    send(32'h8000_0100, 1, 32'hAABB_CCDD, 4'b0101);
    send(32'h8000_0100, 0, 32'h0, 4'hF);
    mem_req_valid = 0;
    wait_resps(3); step();
    n_vec++;
    if (got_q[2] !== 32'h11BB_33DD) begin
      n_err++; $display("FAIL byte_en got %h exp 11bb33dd", got_q[2]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL byte_en_resp%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    mem_resp_ready = 0;
    mem_req_we = 0; mem_req_be = 4'hF; mem_req_valid = 1;
    mem_req_addr = 32'h8000_0000 + 32'($urandom_range(0, 63) << 2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        exp_q.push_back(ref_access(mem_req_addr, 0, 32'h0, 4'hF));
        n_acc++;
      end
      step();
      mem_req_addr = 32'h8000_0000 + 32'($urandom_range(0, 63) << 2);
    end
    mem_req_valid = 0;
    n_vec++;
    if (n_acc != 4) begin
      n_err++; $display("FAIL bp_accepts got %0d exp 4", n_acc);
    end
    n_vec++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL bp_no_pop got %0d pops exp 0", got_q.size());
    end
    mem_resp_ready = 1;
    wait_resps(4);
    step(); step(); step();
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++; $display("FAIL bp_drain_count got %0d exp 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_resp%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_oob();
    int e0 = err_cnt;
    send(32'h0000_1000, 0, 32'h0, 4'hF);
    mem_req_valid = 0;
    n_vec++;
    if ({last_ce, last_err} !== 2'b01) begin
      n_err++; $display("FAIL oob_sram got ce=%b err=%b exp ce=0 err=1", last_ce, last_err);
    end
    step();
    send(32'h8000_0010, 0, 32'h0, 4'hF);
    mem_req_valid = 0;
    wait_resps(2); step(); step();
    n_vec++;
    if (err_cnt - e0 != 1) begin
      n_err++; $display("FAIL oob_pulses got %0d exp 1", err_cnt - e0);
    end
    n_vec++;
    if (got_q[0] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL oob_data got %h exp ffffffff", got_q[0]);
    end
    n_vec++;
    if (got_q[1] !== exp_q[1]) begin
      n_err++; $display("FAIL oob_follow got %h exp %h", got_q[1], exp_q[1]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    mem_resp_ready = 0;
    send(32'h8000_0100, 0, 32'h0, 4'hF);
    send(32'h8000_0010, 0, 32'h0, 4'hF);
    send(32'h8000_0000, 0, 32'h0, 4'hF);
    mem_req_valid = 0;
    rst = 1;
    step(); step();
    rst = 0;
    got_q.delete(); exp_q.delete();
    mem_resp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_resp_valid !== 1'b0) bad++;
      step();
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_mid_quiet got %0d valid cycles exp 0", bad);
    end
    send(32'h8000_0100, 0, 32'h0, 4'hF);
    mem_req_valid = 0;
    wait_resps(1); step(); step(); step();
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL rst_mid_first got n=%0d data %h exp n=1 data %h",
                        got_q.size(), got_q[0], exp_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stream();
    int stalls = 0;
    int r;
    mem_resp_ready = 1;
    for (int i = 0; i < 64; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: mem_req_addr = 32'h8004_0000 + 32'($urandom_range(0, 3));
        1: mem_req_addr = 32'h7FFF_FFFC + 32'($urandom_range(0, 3));
        2: mem_req_addr = 32'h8003_FFFC + 32'($urandom_range(0, 3));
        default: mem_req_addr = 32'h8000_0000 + 32'($urandom_range(0, 255));
      endcase
      mem_req_we = 1'($urandom);
      mem_req_data = $urandom;
      mem_req_be = 4'($urandom);
      mem_req_valid = 1;
      @(negedge clk);
      if (mem_req_ready) exp_q.push_back(ref_access(mem_req_addr, mem_req_we, mem_req_data, mem_req_be));
      else stalls++;
      step();
    end
    mem_req_valid = 0;
    wait_resps(exp_q.size());
    step(); step(); step();
    n_vec++;
    if (stalls != 0) begin
      n_err++; $display("FAIL stream_stalls got %0d exp 0", stalls);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL stream_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL stream_resp%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_en();
    test_backpressure();
    test_oob();
    test_reset_mid();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side endpoint for the core's flat memory port. Consumes the request channel (addr/we/data/be, valid/ready) and produces the response channel (data, valid/ready).
- Drives a single-port synchronous SRAM with fixed read latency.
- Tracks in-flight accesses with a credit counter and buffers responses in a small FIFO, so the core can backpressure responses without losing data.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide
- SRAM_AW, 16, SRAM word-address width (capacity 2^SRAM_AW words)
- BASE_ADDR, 'h80000000, byte address mapped to SRAM word 0
- RD_LATENCY, 1, SRAM cycles from ce to valid rdata (>=1)
- RESP_DEPTH, 4, response FIFO depth; must be >= RD_LATENCY+1

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_req_addr  in  ADDR_WIDTH  byte address
- mem_req_we  in  1  1 = write
- mem_req_data  in  DATA_WIDTH  write data
- mem_req_be  in  DATA_WIDTH/8  byte enables
- mem_req_valid  in  1  request valid
- mem_req_ready  out  1  request accepted when valid&ready
- mem_resp_data  out  DATA_WIDTH  response data
- mem_resp_valid  out  1  response valid
- mem_resp_ready  in  1  core accepts response
- sram_ce  out  1  SRAM access enable
- sram_we  out  1  SRAM write
- sram_addr  out  SRAM_AW  SRAM word address
- sram_be  out  DATA_WIDTH/8  SRAM byte write mask
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid RD_LATENCY cycles after ce
- bus_err  out  1  one-cycle pulse when an out-of-range request is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: mem_req_ready=0, mem_resp_valid=0, mem_resp_data=0, sram_ce=0, sram_we=0, bus_err=0. Credit counter, latency pipe and FIFO are cleared.
- Reset mid-operation: in-flight accesses and buffered responses are discarded. No response is ever emitted for a pre-reset request.
- Credits:
  - outstanding = inflight (latency pipe occupancy) + FIFO count.
  - mem_req_ready = !rst && outstanding < RESP_DEPTH. It is registered/derived from state only and never depends on mem_req_valid.
- Accept: on valid&ready the SRAM is driven combinationally in the same cycle.
  - sram_ce=1 iff the address is in range.
  - sram_we=mem_req_we.
  - sram_be=mem_req_be for writes; all-ones for reads.
  - sram_wdata=mem_req_data.
  - When no request is accepted, sram_ce=0.
- Address map:
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^SRAM_AW, compared as unsigned ADDR_WIDTH.
  - sram_addr = (addr - BASE_ADDR)[SRAM_AW+1:2]. addr[1:0] is ignored (no misalignment fault).
- Out of range: the request is still accepted and consumes a credit. The SRAM is not enabled. Its response data is all-ones. bus_err pulses in the acceptance cycle.
- Every accepted request yields exactly one response, in acceptance order:
  - read: sram_rdata.
  - in-range write: 0.
  - out-of-range request: all-ones.
- Latency pipe: a RD_LATENCY-stage shift of {valid, kind} where kind is read/write/err. At stage end the response word is pushed into the FIFO.
- Latency: with an empty FIFO, mem_resp_valid rises RD_LATENCY+1 cycles after the accept edge (one FIFO register stage).
- Response channel:
  - mem_resp_valid = FIFO non-empty; mem_resp_data = FIFO head.
  - Pop on valid&ready.
  - Data is held stable while valid&&!ready.
- Simultaneous push and pop on the same cycle are both honoured, including when the FIFO is full (pop frees the slot for the push).
- Credits guarantee the FIFO never overflows, so no push is dropped.
- The FIFO pointers are log2(RESP_DEPTH)+1 bits, so pointer wrap-around is unambiguous.
- Throughput: 1 request/cycle sustained while mem_resp_ready=1.

Decomposition:
- Shared types package: mreq/mtrans structs (already shared); add RESP_KIND enum {RK_READ, RK_WRITE, RK_ERR}.
- Sub-module sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty, count.
  - Instantiated once for the response buffer.
  - Reusable elsewhere in the core.

Test Plan:
- Reset then idle: after rst deasserts, mem_req_ready=1 next cycle; sram_ce=0, mem_resp_valid=0 throughout.
- Write then read: write 'h80000010, data 'hCAFEF00D, be 'hF. Read 'h80000010 back. Required: responses 0 then 'hCAFEF00D, in order. The write cycle shows sram_addr=4, sram_we=1.
- Byte-enable write: preload 'h11223344, write 'hAABBCCDD with be 'b0101, read back -> 'h11BB33DD.
- Backpressure: with mem_resp_ready=0, issue reads back-to-back. Required: mem_req_ready drops after exactly RESP_DEPTH accepts. After mem_resp_ready=1, all RESP_DEPTH responses drain in order with no loss or duplication.
- Out of range: read 'h00001000. Required: bus_err pulses once, sram_ce=0, response 'hFFFFFFFF. A following in-range read still returns correct data.
- Reset mid-burst: assert rst with 3 requests in flight. Required: no mem_resp_valid after rst. The first post-reset read returns its own data only.
- Sustained streaming: with mem_resp_ready=1, send 64 random reads/writes at 1/cycle. Required: no ready stall, and responses match a reference model.
